// File: rtl/fnd_pkg.sv
// fnd_pkg: shared types and constants for the seven-segment scan controller.
//   fnd_state_e  conversion FSM state encoding
//   FONT         hex digit font, active-low {dp,g,f,e,d,c,b,a}, entry 0 in bits [7:0]
//   SEG_*        special patterns (blank, dash, E)
//   font_lookup  nibble to segment pattern
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fnd_state_e;

  localparam logic [127:0] FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;

  function automatic logic [7:0] font_lookup(input logic [3:0] nib);
    return FONT[{nib, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// fnd_bin2bcd: sequential double-dabble binary to BCD converter.
//   clk, reset  system clock, synchronous active-high reset (aborts a conversion)
//   start       load din and begin DATA_W shift iterations, one per cycle
//   din         binary input
//   bcd         NUM_DIGITS BCD digits, digit 0 in bits [3:0]
//   ovf         a 1 was shifted out of the top digit
//   done        high during the final iteration; bcd/ovf are valid the next cycle
module fnd_bin2bcd #(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       din,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf,
  output logic                    done
);

  localparam int DIG_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin;
  logic [CNT_W-1:0]  cnt;
  logic [DIG_W-1:0]  adj;

  // +3 correction applied to every digit before the shift
  always_comb begin
    adj = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin <= '0;
      bcd <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      bin <= din;
      bcd <= '0;
      ovf <= 1'b0;
      cnt <= CNT_W'(DATA_W);
    end else if (cnt != '0) begin
      bcd <= {adj[DIG_W-2:0], bin[DATA_W-1]};
      ovf <= ovf | adj[DIG_W-1];
      bin <= bin << 1;
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: channel-select seven-segment display controller.
//   clk, reset  system clock, synchronous active-high reset
//   sel         one-hot channel select (zero or multi-hot shows dashes)
//   ch_data     packed channel values, channel i at [i*DATA_W +: DATA_W]
//   dec_mode    1 = decimal, 0 = hex (ignored without FND_BCD_EN)
//   blank_lz    1 = blank leading zero digits
//   seg         active-low segments {dp,g,f,e,d,c,b,a}
//   seg_comm    active-low digit enables, bit 0 = rightmost
//   busy        decimal conversion in progress
// Build option: define FND_BCD_EN to include the decimal (double-dabble) path.
//
// state | meaning
// IDLE  | snapshot selected value, select-valid and mode
// SHIFT | double-dabble iterations running (FND_BCD_EN only)
// DONE  | load display register, back to IDLE
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 4,
  parameter int DIV_CNT    = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        sel,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     dec_mode,
  input  logic                     blank_lz,
  output logic [7:0]               seg,
  output logic [NUM_DIGITS-1:0]    seg_comm,
  output logic                     busy
);

  localparam int DIG_W = 4 * NUM_DIGITS;
  localparam int EXT_W = (DATA_W > DIG_W) ? DATA_W : DIG_W;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(DIV_CNT);

  fnd_state_e        state, state_nxt;
  logic [DATA_W-1:0] sel_val, snap_val;
  logic              snap_ok, load, load_ovf;
  logic [EXT_W-1:0]  hex_ext;
  logic [DIG_W-1:0]  load_dig, disp_dig, dig_nxt;
  logic              disp_inv, disp_ovf, inv_nxt, ovf_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic              tick;
  logic [3:0]        cur_nib;
  logic              zero_run, lz_blank;
  logic [7:0]        seg_nxt;

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) sel_val = sel_val | ch_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef FND_BCD_EN
  logic             snap_dec, start, cvt_done, cvt_ovf;
  logic [DIG_W-1:0] cvt_bcd;

  fnd_bin2bcd #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (sel_val),
    .bcd   (cvt_bcd),
    .ovf   (cvt_ovf),
    .done  (cvt_done)
  );

  assign busy = (state == SHIFT) || ((state == DONE) && snap_dec);
`else
  logic unused_dec;
  assign unused_dec = dec_mode;
  assign busy       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      snap_val <= '0;
      snap_ok  <= 1'b0;
      disp_dig <= '0;
      disp_inv <= 1'b0;
      disp_ovf <= 1'b0;
`ifdef FND_BCD_EN
      snap_dec <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      disp_dig <= dig_nxt;
      disp_inv <= inv_nxt;
      disp_ovf <= ovf_nxt;
      if (state == IDLE) begin
        snap_val <= sel_val;
        snap_ok  <= $onehot(sel);
`ifdef FND_BCD_EN
        snap_dec <= dec_mode;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
`ifdef FND_BCD_EN
    start     = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef FND_BCD_EN
        start     = dec_mode;
        state_nxt = dec_mode ? SHIFT : DONE;
`else
        state_nxt = DONE;
`endif
      end
`ifdef FND_BCD_EN
      SHIFT: if (cvt_done) state_nxt = DONE;
`endif
      DONE: begin
        load      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hex result: zero-extended snapshot; anything above the displayable nibbles is overflow
  always_comb begin
    hex_ext  = EXT_W'(snap_val);
    load_dig = hex_ext[DIG_W-1:0];
    load_ovf = |(hex_ext >> DIG_W);
`ifdef FND_BCD_EN
    if (snap_dec) begin
      load_dig = cvt_bcd;
      load_ovf = cvt_ovf;
    end
`endif
  end

  // A tick coinciding with a DONE load must show the freshly loaded value
  assign dig_nxt = load ? load_dig : disp_dig;
  assign inv_nxt = load ? ~snap_ok : disp_inv;
  assign ovf_nxt = load ? load_ovf : disp_ovf;

  assign tick = (div_cnt == DIV_W'(DIV_CNT - 1));

  // zero_run tracks "this digit and all above it are zero", scanning top-down
  always_comb begin
    cur_nib  = '0;
    zero_run = 1'b1;
    lz_blank = 1'b0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      zero_run = zero_run & (dig_nxt[4*d +: 4] == 4'd0);
      if (IDX_W'(d) == dig_idx) begin
        cur_nib  = dig_nxt[4*d +: 4];
        lz_blank = zero_run && (d != 0);
      end
    end
    if (inv_nxt)                   seg_nxt = SEG_DASH;
    else if (ovf_nxt)              seg_nxt = SEG_E;
    else if (blank_lz && lz_blank) seg_nxt = SEG_BLANK;
    else                           seg_nxt = font_lookup(cur_nib);
  end

  // dig_idx names the digit the next tick will drive
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      dig_idx  <= '0;
      seg      <= SEG_BLANK;
      seg_comm <= '1;
    end else if (tick) begin
      div_cnt  <= '0;
      dig_idx  <= (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
      seg      <= seg_nxt;
      seg_comm <= ~(NUM_DIGITS'(1) << dig_idx);
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Parametrised seven-segment display controller for the board-level debug display. It selects one of `NUM_CH` register channels with a one-hot select and renders the value in hex or decimal on `NUM_DIGITS` multiplexed digits. Decimal conversion is sequential (double-dabble). Features: leading-zero blanking, invalid-select and overflow indication. It sits between the slave register bank and the board FND pins.

## Interface
- `NUM_CH`, 3: number of input channels.
- `DATA_W`, 8: bits per channel.
- `NUM_DIGITS`, 4: number of display digits (≥2).
- `DIV_CNT`, 100000: clock cycles per digit scan step (≥2).

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  NUM_CH  one-hot channel select. Bit i selects channel i.
- `ch_data`  in  NUM_CH*DATA_W  packed channel values. Channel i is bits [i*DATA_W +: DATA_W].
- `dec_mode`  in  1  1 = decimal, 0 = hex.
- `blank_lz`  in  1  1 = blank leading zero digits.
- `seg`  out  8  segment pattern, active-low, bit order {dp,g,f,e,d,c,b,a}.
- `seg_comm`  out  NUM_DIGITS  digit enables, active-low. Bit 0 is the rightmost digit.
- `busy`  out  1  high while a decimal conversion is in progress.

## Operation
- Conversion FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: captures the selected value, `dec_mode` and a select-valid flag into a snapshot.
    - Decimal mode: next state is SHIFT.
    - Hex mode: next state is DONE.
  - SHIFT: runs exactly DATA_W double-dabble iterations, one per cycle, over NUM_DIGITS BCD digits.
    - Before each shift, every digit ≥5 gets +3.
    - A 1 shifted out of the top digit sets overflow.
  - DONE: loads the display register (NUM_DIGITS nibbles plus flags), then returns to IDLE. Conversion repeats continuously.
- Hex mode: nibbles are taken directly from the snapshot, zero-extended. Overflow is set if any snapshot bit at or above position 4*NUM_DIGITS is 1.
- Invalid select (`sel` is zero or has more than one bit set): every digit shows a dash (8'hBF). This overrides overflow.
- Overflow: every digit shows E (8'h86).
- Leading-zero blanking (`blank_lz`=1): every zero digit above the most significant nonzero digit shows 8'hFF. Digit 0 is never blanked. No blanking is applied under dash or E display.
- Font: 0–F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E. The dp bit is always 1 (off).
- Scan:
  - A divider counts 0..DIV_CNT-1 and emits a tick on the wrap.
  - On each tick, the digit index advances modulo NUM_DIGITS.
  - On that same tick, `seg` and `seg_comm` are registered for the new index. `seg_comm` = ~(1<<index).

## Timing
- Reset values: `seg`=8'hFF; `seg_comm`=all ones; `busy`=0; FSM in IDLE; divider 0.
- After reset, digit index and display register are 0.
- Reset aborts SHIFT in the same cycle. The result is discarded.
- The first tick occurs DIV_CNT cycles after reset release and drives digit 0 (`seg_comm`=…1110).
- Conversion period: DATA_W+2 cycles in decimal mode, 2 cycles in hex mode.
- `busy` is asserted in SHIFT and in the DONE that follows it.
- Input-change latency:
  - Input change to display register: ≤ 2*(DATA_W+2) cycles.
  - Display register to pins: at the next tick of the affected digit.
- `sel`, `ch_data` and `dec_mode` are sampled only in IDLE. Changes during SHIFT do not corrupt the result in flight.
- `blank_lz` is applied combinationally at output registration.
- A DONE load in the same cycle as a tick: the tick uses the newly loaded display register.

## Configuration
- `FND_BCD_EN` defined: decimal path present as described.
- `FND_BCD_EN` not defined:
  - SHIFT state and the BCD converter are not built.
  - `dec_mode` is ignored; display is always hex.
  - `busy` is tied to 0.

## Structure
- Package `fnd_pkg` holds:
  - the FSM state enum (IDLE/SHIFT/DONE);
  - the 16-entry font constant;
  - constants `SEG_BLANK`=8'hFF, `SEG_DASH`=8'hBF, `SEG_E`=8'h86.
- Sub-module `fnd_bin2bcd`: sequential double-dabble converter with start/done handshake and overflow output. It is instantiated only under `FND_BCD_EN`.

## Test plan
- Decimal with blanking (DIV_CNT=4, NUM_DIGITS=4): `sel`=001, ch0=8'd255, `dec_mode`=1, `blank_lz`=1. Over digits 0..3, `seg` must be 92,92,A4,FF.
- Hex with blanking: same stimulus with `dec_mode`=0. Over digits 0..3, `seg` must be 8E,8E,FF,FF.
  - With `blank_lz`=0, digits 2..3 must show C0,C0.
- Scan sequence: `seg_comm` must be FF until cycle 4, then 1110,1101,1011,0111,1110, each held 4 cycles. Invalid select `sel`=011 or 000 must give `seg`=BF on all digits.
- Overflow (DATA_W=16, NUM_DIGITS=4): decimal input 12345 must give `seg`=86 on all digits. Hex input 16'h1234 must give 4,3,2,1 (99,B0,A4,F9).
- Reset mid-operation: assert `reset` for 1 cycle during SHIFT (input 8'd200). Next cycle must show `busy`=0, `seg`=FF and `seg_comm`=all ones. After release, the display must show 200 after one full conversion.
